// File: rtl/mult_sequencer.sv
// Sequential 8x8 unsigned shift-and-add multiplier that borrows an external
// 9-bit adder: one partial-product add per cycle, eight cycles per multiply.
module mult_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    output logic        add_en,
    input  logic [8:0]  add_s,
    output logic [15:0] product,
    output logic        busy,
    output logic        done,
    output logic [1:0]  state_dbg
);

    // Handshake: start is a request sampled on each rising edge; it is taken
    // only in IDLE or DONE (never while busy). busy is high for exactly the
    // eight ADD cycles, then done pulses for one cycle with product valid.
    // product keeps that value until the next accepted start.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  m_reg;
    logic [7:0]  acc;
    logic [7:0]  q_reg;
    logic [3:0]  cnt;
    logic        rst_hold;
    logic        accept;
    logic        load;
    logic        step;

    // rst_hold masks start on the first edge after reset release, so a start
    // that coincides with that edge cannot launch a multiply.
    assign accept = start && !rst_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load       = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                step = 1'b1;
                if (cnt == 4'd7) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    load       = 1'b1;
                    state_next = ADD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // add_s is only consumed in ADD, so a floating bus elsewhere never leaks in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reg    <= 8'd0;
            acc      <= 8'd0;
            q_reg    <= 8'd0;
            cnt      <= 4'd0;
            rst_hold <= 1'b1;
        end else begin
            rst_hold <= 1'b0;
            if (load) begin
                m_reg <= a;
                acc   <= 8'd0;
                q_reg <= b;
                cnt   <= 4'd0;
            end else if (step) begin
                acc   <= add_s[8:1];
                q_reg <= {add_s[0], q_reg[7:1]};
                cnt   <= cnt + 4'd1;
            end
        end
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        add_en = 1'b0;
        add_a  = 8'd0;
        add_b  = 8'd0;
        case (state)
            ADD: begin
                busy   = 1'b1;
                add_en = 1'b1;
                add_a  = acc;
                add_b  = q_reg[0] ? m_reg : 8'd0;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign product   = {acc, q_reg};
    assign state_dbg = state;

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 8 bits to match the 9-bit-sum adder stage.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new multiply; sampled on the rising clk edge.
REQ-005 a  input  8  multiplicand, unsigned; sampled with start.
REQ-006 b  input  8  multiplier, unsigned; sampled with start.
REQ-007 add_a  output  8  operand a driven to the downstream enabled adder.
REQ-008 add_b  output  8  operand b driven to the downstream enabled adder.
REQ-009 add_en  output  1  enable for the adder's tri-state result bus.
REQ-010 add_s  input  9  9-bit sum returned by the adder, valid only while add_en=1.
REQ-011 product  output  16  unsigned result a*b.
REQ-012 busy  output  1  high while a multiply is in progress.
REQ-013 done  output  1  one-cycle pulse when product becomes valid.

Function
REQ-014 FSM states SHALL be IDLE, ADD and DONE; encoding is free.
REQ-015 Internal registers SHALL be: M[7:0] (multiplicand), A[7:0] (accumulator), Q[7:0] (multiplier/low product) and cnt[3:0].
REQ-016 IDLE or DONE with start=1 SHALL load M=a, Q=b, A=0, cnt=0 and go to ADD.
REQ-017 IDLE with start=0 SHALL hold all state.
REQ-018 DONE with start=0 SHALL go to IDLE.
REQ-019 In ADD, the block SHALL drive add_a=A, add_b=(Q[0] ? M : 0) and add_en=1, combinationally from registers.
REQ-020 At each ADD edge the block SHALL update A <= add_s[8:1], Q <= {add_s[0], Q[7:1]}, cnt <= cnt+1.
REQ-021 ADD with cnt=7 at the edge SHALL go to DONE after its update; exactly 8 ADD cycles SHALL occur.
REQ-022 product SHALL equal {A,Q} in DONE and SHALL hold that value in IDLE until the next accepted start.
REQ-023 During ADD, product is don't-care.
REQ-024 Latency: a start sampled at edge k SHALL give done=1 in the cycle following edge k+8, i.e. 9 cycles.
REQ-025 busy SHALL be 1 exactly in ADD; done SHALL be 1 exactly in DONE.
REQ-026 A start asserted while in ADD SHALL be ignored; the in-flight operands SHALL NOT change.
REQ-027 A start held continuously SHALL launch a new multiply from every DONE (back-to-back, 9-cycle period).
REQ-028 Outside ADD, add_en=0 and add_a=add_b=0.
REQ-029 add_s SHALL NOT be sampled outside ADD; high-Z/X on add_s there SHALL NOT affect any register.
REQ-030 The arithmetic SHALL be unsigned; 255*255 SHALL give 0xFE01 with no overflow lost, because add_s[8] is retained each step.

Reset
REQ-031 rst=1 SHALL immediately, without a clock, force state=IDLE, M=A=Q=0, cnt=0, product=0, busy=0, done=0, add_en=0, add_a=add_b=0.
REQ-032 Reset mid-ADD SHALL abort the operation with no done pulse.
REQ-033 After rst deasserts, the first start SHALL be accepted normally.
REQ-034 start coincident with the rst deassertion edge SHALL be ignored.

Verification
REQ-035 Basic multiply: a=13, b=11, 1-cycle start -> busy high 8 cycles; done pulse at cycle 9; product=143 (0x008F); add_en high exactly 8 cycles.
REQ-036 Corner values: a=255, b=255 -> product=0xFE01. a=0, b=200 -> 0x0000. a=200, b=1 -> 0x00C8. a=1, b=128 -> 0x0080.
REQ-037 Start while busy: a=3, b=5 start, then start with a=9, b=9 at cycle 4 -> product=15; no second operation begins.
REQ-038 Continuous start: start held high with a=2, b=7 -> done every 9 cycles; product=14 each time.
REQ-039 Reset mid-operation: rst pulsed asynchronously between edges at cycle 5 -> all outputs 0 within the same cycle; no done; a subsequent multiply a=6, b=7 -> 42.
REQ-040 Bus isolation: adder model drives add_s=Z/X while add_en=0 -> product and internal state unaffected; randomized 1000 pairs -> product=a*b.
